multiword_adder_seq: RTL and testbench
======================================

# multiword_adder_seq

Multi-cycle wide adder/subtractor that computes a K·N-bit sum using one N-bit ripple-carry adder, processing one N-bit word per cycle from least to most significant and carrying between words through a register. It sits in the datapath wherever a wide add is needed and area matters more than latency. It fronts the shared narrow adder with a valid/ready operand port and a valid/ready result port.

## Interface
- N, 8: width of the internal adder (bits per word); N ≥ 1.
- K, 4: number of words per operand; K ≥ 1. Operand width W = N·K.

- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand transaction offered.
- in_ready  output  1  block accepts operands this cycle.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in for add. Ignored when sub=1.
- sub  input  1  1 selects A − B. This is computed as A + ~B + 1.
- s  output  W  result.
- cout  output  1  carry out of bit W−1. For subtract, 1 means no borrow (A ≥ B unsigned).
- out_valid  output  1  s/cout hold a completed result.
- out_ready  input  1  consumer takes the result this cycle.

## Operation
- Datapath: a single N-bit ripple adder. Its inputs are word idx of the A register and the (possibly inverted) B register, plus the carry register `c`.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1: latch a; latch b, or ~b if sub=1; set c = (sub ? 1 : cin); set idx=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: word idx of s ← adder sum; c ← adder carry-out; idx ← idx+1.
  - When idx = K−1, the cycle also sets cout ← adder carry-out and moves to DONE.
- DONE:
  - in_ready=0, out_valid=1.
  - s and cout are held stable.
  - On out_ready=1 go to IDLE.
- Handshake rules:
  - Operands transfer on an edge where in_valid & in_ready.
  - The result transfers on an edge where out_valid & out_ready.
  - in_valid is ignored outside IDLE. Operands are not re-sampled, and a/b/cin/sub may change freely after acceptance.
  - out_valid does not drop until out_ready is seen.
- Arithmetic is modulo 2^W with carry-out in cout. There is no signed overflow flag.
- s is undefined (implementation may show partial words) while out_valid=0. Only the DONE value is specified.
- K=1: RUN lasts exactly one cycle.
- Reset (any state, including mid-RUN or DONE), asynchronously:
  - State ← IDLE.
  - s ← 0, cout ← 0, c ← 0, idx ← 0, operand registers ← 0.
  - out_valid=0, in_ready=1.
  - Any in-flight transaction is discarded.

## Timing
- in_ready and out_valid are decoded directly from the state register, with no combinational path from inputs.
- Latency: operands accepted at edge T give out_valid=1 from edge T+K.
- Minimum transaction period is K+2 cycles: accept, K RUN cycles, at least one DONE cycle, then one IDLE cycle before the next accept.
- The next accept may occur at the edge T+K+1 that leaves DONE only if the block is in IDLE. in_ready is 0 in the DONE cycle itself.
- Critical path: one N-bit ripple chain plus the carry-register setup.

## Test plan
- Word-boundary carry. N=8, K=4, a=0x000000FF, b=0x00000001, cin=0, sub=0:
  - s=0x00000100, cout=0.
  - out_valid rises exactly 4 cycles after the accept edge.
- Full-width carry propagation. a=0xFFFFFFFF, b=0x00000000, cin=1:
  - s=0x00000000, cout=1.
  - Then a=0x80000000, b=0x80000000, cin=0: s=0, cout=1.
- Subtract:
  - a=7, b=5, sub=1, cin=1 (must be ignored): s=0x00000002, cout=1.
  - a=5, b=7, sub=1: s=0xFFFFFFFE, cout=0.
- Backpressure and ignored input:
  - Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - Required: out_valid=1, s and cout unchanged, in_ready=0, no new operands captured.
  - After out_ready=1, one IDLE cycle, then the new operands are accepted and produce the correct result.
- Reset mid-operation:
  - Assert rst_n=0 during the 2nd RUN cycle. Immediately: out_valid=0, in_ready=1, s=0, cout=0.
  - After release, a fresh transaction a=1, b=2 gives s=3, cout=0.
- Randomized stream, N=8 with K=1 and K=4:
  - Random a/b/cin/sub with random in_valid/out_ready stalls.
  - Every result matches the reference model {cout,s} = a + (sub ? ~b+1 : b + cin) at width W+1.
  - No transaction is dropped or duplicated.

Source files
------------

// File: rtl/multiword_adder_seq.sv
// -----------------------------------------------------------------------------
// multiword_adder_seq
//
// Wide (N*K-bit) adder/subtractor built around a single N-bit ripple adder.
// One word is processed per cycle, least significant first. The carry between
// words is kept in a register. Subtraction is performed as A + ~B + 1.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand transaction offered
//   in_ready   block is idle and accepts operands this cycle
//   a, b       W-bit operands (W = N*K)
//   cin        carry-in for add (ignored when sub=1)
//   sub        1 selects A - B
//   s          W-bit result (meaningful only while out_valid=1)
//   cout       carry out of bit W-1 (for subtract: 1 means no borrow)
//   out_valid  s/cout hold a completed result
//   out_ready  consumer takes the result this cycle
// -----------------------------------------------------------------------------
module multiword_adder_seq #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*K-1:0] a,
    input  logic [N*K-1:0] b,
    input  logic           cin,
    input  logic           sub,
    output logic [N*K-1:0] s,
    output logic           cout,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int W  = N * K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;      // already inverted when subtracting
    logic            c_r;      // carry into the current word
    logic [IW-1:0]   idx_r;
    logic [W-1:0]    s_r;
    logic            cout_r;

    logic [N-1:0]    a_word_s;
    logic [N-1:0]    b_word_s;
    logic [N:0]      sum_s;
    logic            last_s;

    // Shared N-bit adder on the current word plus the inter-word carry.
    always_comb begin
        a_word_s = a_r[idx_r*N +: N];
        b_word_s = b_r[idx_r*N +: N];
        sum_s    = {1'b0, a_word_s} + {1'b0, b_word_s} + {{N{1'b0}}, c_r};
        last_s   = (idx_r == IDX_LAST);
    end

    // Next-state decode for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, per-word accumulation and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= {W{1'b0}};
            b_r    <= {W{1'b0}};
            c_r    <= 1'b0;
            idx_r  <= IDX_ZERO;
            s_r    <= {W{1'b0}};
            cout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        // Subtract folds the "+1" of two's complement into the carry.
                        c_r   <= sub ? 1'b1 : cin;
                        idx_r <= IDX_ZERO;
                    end
                end
                ST_RUN: begin
                    s_r[idx_r*N +: N] <= sum_s[N-1:0];
                    c_r               <= sum_s[N];
                    if (last_s) begin
                        cout_r <= sum_s[N];
                        // Park the index on word 0 so it never points past the operand.
                        idx_r  <= IDX_ZERO;
                    end else begin
                        idx_r  <= idx_r + IDX_ONE;
                    end
                end
                ST_DONE: begin
                    // Result is held until the consumer takes it.
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake flags come straight from the state register.
    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign s         = s_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// -----------------------------------------------------------------------------
// tb_multiword_adder_seq
//
// Bench for multiword_adder_seq. Two instances (N=8,K=4 and N=8,K=1) share
// one operand/handshake bus. Directed vectors and sequences target the K=4
// instance; a negedge monitor per instance scores every transfer against an
// arithmetic reference model through an expected-result queue.
// -----------------------------------------------------------------------------
module tb_multiword_adder_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_ready;

    logic        in_ready4;
    logic [31:0] s4;
    logic        cout4;
    logic        out_valid4;

    logic        in_ready1;
    logic [7:0]  s1;
    logic        cout1;
    logic        out_valid1;

    int n_vec;
    int n_err;
    int acc4, done4, acc1, done1;

    logic [32:0] q4[$];
    logic [32:0] q1[$];

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] exp_s;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[8];

    multiword_adder_seq #(.N(8), .K(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .s         (s4),
        .cout      (cout4),
        .out_valid (out_valid4),
        .out_ready (out_ready)
    );

    multiword_adder_seq #(.N(8), .K(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .a         (a[7:0]),
        .b         (b[7:0]),
        .cin       (cin),
        .sub       (sub),
        .s         (s1),
        .cout      (cout1),
        .out_valid (out_valid1),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference: {cout,s} = a + (sub ? ~b + 1 : b + cin) at width w+1.
    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic sb, input int w);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (64'd1 << w) - 64'd1;
        if (sb) begin
            r = ({32'd0, x} & mask) + ({32'd0, ~y} & mask) + 64'd1;
        end else begin
            r = ({32'd0, x} & mask) + ({32'd0, y} & mask) + {63'd0, ci};
        end
        return r[32:0];
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // An in-flight transaction is lost on reset.
    always @(negedge rst_n) begin
        q4.delete();
        q1.delete();
    end

    // Scoreboard for the K=4 instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (in_valid && in_ready4) begin
                q4.push_back(model(a, b, cin, sub, 32));
                acc4 = acc4 + 1;
            end
            if (out_valid4 && out_ready) begin
                done4 = done4 + 1;
                if (q4.size() == 0) begin
                    n_vec = n_vec + 1;
                    n_err = n_err + 1;
                    $display("FAIL stream4_extra: got result %h with no pending transaction", {cout4, s4});
                end else begin
                    check("stream4", {31'd0, cout4, s4}, {31'd0, q4.pop_front()});
                end
            end
        end
    end

    // Scoreboard for the K=1 instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (in_valid && in_ready1) begin
                q1.push_back(model(a, b, cin, sub, 8));
                acc1 = acc1 + 1;
            end
            if (out_valid1 && out_ready) begin
                done1 = done1 + 1;
                if (q1.size() == 0) begin
                    n_vec = n_vec + 1;
                    n_err = n_err + 1;
                    $display("FAIL stream1_extra: got result %h with no pending transaction", {cout1, s1});
                end else begin
                    check("stream1", {55'd0, cout1, s1}, {31'd0, q1.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready4(input string nm);
        int n;
        n = 0;
        while (!in_ready4 && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready4) check({nm, "_ready_timeout"}, 64'd0, 64'd1);
    endtask

    // One K=4 transaction: latency, result and cout are checked, then consumed.
    task automatic run4(input string nm, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic ts, input logic [31:0] es, input logic ec);
        int lat;
        wait_ready4(nm);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'b1; sub = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            tick();
            lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'd4);
        check({nm, "_s"}, {32'd0, s4}, {32'd0, es});
        check({nm, "_cout"}, {63'd0, cout4}, {63'd0, ec});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'd0; b = 32'd0; cin = 1'b0; sub = 1'b0;
        n_vec = 0; n_err = 0; acc4 = 0; done4 = 0; acc1 = 0; done1 = 0;

        vecs[0] = '{"word_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
        vecs[1] = '{"full_carry", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[2] = '{"msb_carry",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
        vecs[3] = '{"sub_pos",    32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1};
        vecs[4] = '{"sub_neg",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0};
        vecs[5] = '{"sub_zero",   32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1};
        vecs[6] = '{"mixed_add",  32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0};
        vecs[7] = '{"all_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1};

        tick();
        tick();
        check("rst_in_ready",  {63'd0, in_ready4},  64'd1);
        check("rst_out_valid", {63'd0, out_valid4}, 64'd0);
        check("rst_s",         {32'd0, s4},         64'd0);
        check("rst_cout",      {63'd0, cout4},      64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run4(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                 vecs[i].exp_s, vecs[i].exp_cout);
        end

        // Backpressure: result must hold and new operands must be ignored in DONE.
        wait_ready4("bp");
        a = 32'h10; b = 32'h20; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        a = 32'h0000_DEAD; b = 32'h0000_BEEF;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            tick();
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {63'd0, out_valid4}, 64'd1);
            check("bp_in_ready",  {63'd0, in_ready4},  64'd0);
            check("bp_hold",      {31'd0, cout4, s4},  64'h30);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle_in_ready",  {63'd0, in_ready4},  64'd1);
        check("bp_idle_out_valid", {63'd0, out_valid4}, 64'd0);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_next_latency", 64'(lat), 64'd4);
        check("bp_next_result", {31'd0, cout4, s4}, 64'h1_9D9C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during the second RUN cycle.
        wait_ready4("rst_mid");
        a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", {63'd0, out_valid4}, 64'd0);
        check("rst_mid_in_ready",  {63'd0, in_ready4},  64'd1);
        check("rst_mid_s",         {32'd0, s4},         64'd0);
        check("rst_mid_cout",      {63'd0, cout4},      64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run4("rst_fresh", 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0);

        // Random stream with stalls on both sides, scored by the monitors.
        for (int i = 0; i < 1500; i++) begin
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) b = 32'h0000_0000;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();
        out_ready = 1'b0;

        check("drain_q4", 64'(q4.size()), 64'd0);
        check("drain_q1", 64'(q1.size()), 64'd0);
        check("progress4", 64'(acc4 > 100), 64'd1);
        check("progress1", 64'(acc1 > 200), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
